// File: rtl/huffman_merge_ctrl.sv
// -----------------------------------------------------------------------------
// huffman_merge_ctrl
//
// Drives a shared descending sorter to build Huffman node weights. A vector
// of DEPTH symbol weights is loaded and handed to the sorter. After each sort
// the two smallest active weights are merged into one node. Every merge is
// reported, until a single root weight remains.
//
// Parameters
//   DEPTH        number of symbol weights (>= 1)
//   WIDTH        bits per weight
//
// Ports
//   clock        rising-edge clock
//   rstn         synchronous active-low reset
//   start        job request, sampled only while idle
//   in_weights   initial weights, entry k = bits [k*WIDTH +: WIDTH]
//   busy         high whenever a job is in progress
//   sort_valid   one-cycle sorter request per round
//   sort_data    working vector presented to the sorter
//   sort_result  sorter output, descending, entry 0 largest
//   sort_ready   sorter completion level
//   merge_valid  one-cycle pulse per merge
//   merge_lo     smallest active weight of the round
//   merge_hi     second-smallest active weight of the round
//   merge_sum    merged node weight
//   merge_idx    merge number, 0..DEPTH-2
//   done         one-cycle pulse when the root is complete
//   root_weight  final root weight, held until the next start
//
// Build option
//   HUFF_MERGE_SAT_EN  when defined, merged sums saturate at 2^WIDTH-1;
//                      otherwise they wrap modulo 2^WIDTH.
// -----------------------------------------------------------------------------
module huffman_merge_ctrl #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     rstn,
    input  logic                     start,
    input  logic [DEPTH*WIDTH-1:0]   in_weights,
    output logic                     busy,
    output logic                     sort_valid,
    output logic [DEPTH*WIDTH-1:0]   sort_data,
    input  logic [DEPTH*WIDTH-1:0]   sort_result,
    input  logic                     sort_ready,
    output logic                     merge_valid,
    output logic [WIDTH-1:0]         merge_lo,
    output logic [WIDTH-1:0]         merge_hi,
    output logic [WIDTH-1:0]         merge_sum,
    output logic [$clog2(DEPTH):0]   merge_idx,
    output logic                     done,
    output logic [WIDTH-1:0]         root_weight
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_LO,
        WAIT_HI,
        MERGE,
        FINISH
    } state_t;

    state_t                 state;
    logic [DEPTH*WIDTH-1:0] work_buf;
    logic [CNT_W-1:0]       n_act;

    logic [WIDTH-1:0]       lo_w;
    logic [WIDTH-1:0]       hi_w;
    logic [WIDTH:0]         raw_sum;
    logic [WIDTH-1:0]       sum_w;
    logic [DEPTH*WIDTH-1:0] merged_buf;

    assign busy       = (state != IDLE);
    assign sort_valid = (state == ISSUE);
    assign sort_data  = work_buf;

    // The sorted vector keeps active weights in entries 0..n-1, so the two
    // smallest active weights sit at entries n-1 and n-2.
    always_comb begin
        // NOTE: every combinational output gets a default before the loop so
        // no path leaves it unassigned, which would infer a latch.
        lo_w = '0;
        hi_w = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (k == int'(n_act) - 1) lo_w = work_buf[k*WIDTH +: WIDTH];
            if (k == int'(n_act) - 2) hi_w = work_buf[k*WIDTH +: WIDTH];
        end
    end

    assign raw_sum = {1'b0, lo_w} + {1'b0, hi_w};

`ifdef HUFF_MERGE_SAT_EN
    assign sum_w = raw_sum[WIDTH] ? '1 : raw_sum[WIDTH-1:0];
`else
    assign sum_w = raw_sum[WIDTH-1:0];
`endif

    // Merged node replaces entry n-2; entry n-1 becomes an inactive zero,
    // which the next sort pushes to the bottom with the other inactive zeros.
    always_comb begin
        merged_buf = work_buf;
        for (int k = 0; k < DEPTH; k++) begin
            if (k == int'(n_act) - 2) merged_buf[k*WIDTH +: WIDTH] = sum_w;
            if (k == int'(n_act) - 1) merged_buf[k*WIDTH +: WIDTH] = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clock) begin
        if (!rstn) begin
            state       <= IDLE;
            // NOTE: the working vector is reset too, because it is visible on
            // sort_data and must read zero after reset.
            work_buf    <= '0;
            n_act       <= '0;
            merge_valid <= 1'b0;
            merge_lo    <= '0;
            merge_hi    <= '0;
            merge_sum   <= '0;
            merge_idx   <= '0;
            done        <= 1'b0;
            root_weight <= '0;
        end else begin
            merge_valid <= 1'b0;
            done        <= 1'b0;

            // The index advances once the pulse that carried it has been seen.
            if (merge_valid) merge_idx <= merge_idx + 1'b1;

            case (state)
                IDLE: begin
                    if (start) begin
                        work_buf    <= in_weights;
                        n_act       <= CNT_W'(DEPTH);
                        merge_idx   <= '0;
                        root_weight <= '0;
                        state       <= (DEPTH == 1) ? FINISH : ISSUE;
                    end
                end

                ISSUE: begin
                    state <= WAIT_LO;
                end

                // A ready level left high by the previous round must drop
                // before a rising ready can be trusted as completion.
                WAIT_LO: begin
                    if (!sort_ready) state <= WAIT_HI;
                end

                WAIT_HI: begin
                    if (sort_ready) begin
                        work_buf <= sort_result;
                        state    <= MERGE;
                    end
                end

                MERGE: begin
                    merge_lo    <= lo_w;
                    merge_hi    <= hi_w;
                    merge_sum   <= sum_w;
                    merge_valid <= 1'b1;
                    work_buf    <= merged_buf;
                    n_act       <= n_act - 1'b1;
                    state       <= (n_act == CNT_W'(2)) ? FINISH : ISSUE;
                end

                FINISH: begin
                    root_weight <= work_buf[WIDTH-1:0];
                    done        <= 1'b1;
                    state       <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_huffman_merge_ctrl.sv
// -----------------------------------------------------------------------------
// tb_huffman_merge_ctrl
//
// Self-checking bench for huffman_merge_ctrl. A DEPTH=8 instance is driven
// through directed and random jobs against a behavioural sorter and a
// multiset-based merge model; a DEPTH=1 instance covers the degenerate job.
// -----------------------------------------------------------------------------
module tb_huffman_merge_ctrl;

    localparam int DEPTH = 8;
    localparam int WIDTH = 8;

    logic        clock = 1'b0;
    logic        rstn  = 1'b0;
    logic        start = 1'b0;
    logic [63:0] in_weights = '0;
    logic        busy;
    logic        sort_valid;
    logic [63:0] sort_data;
    logic [63:0] sort_result = '0;
    logic        sort_ready  = 1'b0;
    logic        merge_valid;
    logic [7:0]  merge_lo;
    logic [7:0]  merge_hi;
    logic [7:0]  merge_sum;
    logic [3:0]  merge_idx;
    logic        done;
    logic [7:0]  root_weight;

    logic        start1 = 1'b0;
    logic [7:0]  in_weights1 = 8'd9;
    logic        busy1;
    logic        sort_valid1;
    logic [7:0]  sort_data1;
    logic        merge_valid1;
    logic [7:0]  merge_lo1;
    logic [7:0]  merge_hi1;
    logic [7:0]  merge_sum1;
    logic [0:0]  merge_idx1;
    logic        done1;
    logic [7:0]  root_weight1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    huffman_merge_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_dut (
        .clock       (clock),
        .rstn        (rstn),
        .start       (start),
        .in_weights  (in_weights),
        .busy        (busy),
        .sort_valid  (sort_valid),
        .sort_data   (sort_data),
        .sort_result (sort_result),
        .sort_ready  (sort_ready),
        .merge_valid (merge_valid),
        .merge_lo    (merge_lo),
        .merge_hi    (merge_hi),
        .merge_sum   (merge_sum),
        .merge_idx   (merge_idx),
        .done        (done),
        .root_weight (root_weight)
    );

    huffman_merge_ctrl #(.DEPTH(1), .WIDTH(WIDTH)) u_dut1 (
        .clock       (clock),
        .rstn        (rstn),
        .start       (start1),
        .in_weights  (in_weights1),
        .busy        (busy1),
        .sort_valid  (sort_valid1),
        .sort_data   (sort_data1),
        .sort_result (8'd0),
        .sort_ready  (1'b0),
        .merge_valid (merge_valid1),
        .merge_lo    (merge_lo1),
        .merge_hi    (merge_hi1),
        .merge_sum   (merge_sum1),
        .merge_idx   (merge_idx1),
        .done        (done1),
        .root_weight (root_weight1)
    );

    // ---------------- behavioural sorter ----------------
    int          stale_hold   = 0;
    int          sort_latency = 10;
    int          hold_cnt     = 0;
    int          lat_cnt      = 0;
    int          n_sort_req   = 0;
    logic [63:0] req_data     = '0;

    function automatic logic [63:0] sort_desc(input logic [63:0] v);
        int          q[$];
        logic [63:0] r;
        for (int k = 0; k < DEPTH; k++) q.push_back(int'(v[k*8 +: 8]));
        q.rsort();
        r = '0;
        for (int k = 0; k < DEPTH; k++) r[k*8 +: 8] = 8'(q[k]);
        return r;
    endfunction

    always @(posedge clock) begin
        if (!rstn) begin
            sort_ready <= 1'b0;
            hold_cnt   <= 0;
            lat_cnt    <= 0;
        end else if (sort_valid) begin
            n_sort_req++;
            req_data <= sort_data;
            hold_cnt <= stale_hold;
            lat_cnt  <= sort_latency;
            if (stale_hold == 0) sort_ready <= 1'b0;
        end else if (hold_cnt > 0) begin
            hold_cnt <= hold_cnt - 1;
            if (hold_cnt == 1) sort_ready <= 1'b0;
        end else if (lat_cnt > 0) begin
            lat_cnt <= lat_cnt - 1;
            if (lat_cnt == 1) begin
                sort_ready  <= 1'b1;
                sort_result <= sort_desc(req_data);
            end
        end
    end

    // ---------------- merge monitor ----------------
    int got_lo[$];
    int got_hi[$];
    int got_sum[$];
    int got_idx[$];
    int got_sv[$];

    always @(negedge clock) begin
        if (merge_valid === 1'b1) begin
            got_lo.push_back(int'(merge_lo));
            got_hi.push_back(int'(merge_hi));
            got_sum.push_back(int'(merge_sum));
            got_idx.push_back(int'(merge_idx));
            got_sv.push_back(int'(sort_valid));
        end
    end

    // ---------------- reference model ----------------
    int job_w[DEPTH];
    int exp_lo[$];
    int exp_hi[$];
    int exp_sum[$];
    int exp_root;

    // Huffman merging over the multiset of active weights: always combine
    // the two smallest, with the sum wrapped or saturated to 8 bits.
    task automatic model_job();
        int act[$];
        int lo;
        int hi;
        int s;
        exp_lo.delete();
        exp_hi.delete();
        exp_sum.delete();
        for (int k = 0; k < DEPTH; k++) act.push_back(job_w[k]);
        while (act.size() > 1) begin
            act.sort();
            lo = act.pop_front();
            hi = act.pop_front();
            s  = lo + hi;
`ifdef HUFF_MERGE_SAT_EN
            if (s > 255) s = 255;
`else
            s = s % 256;
`endif
            exp_lo.push_back(lo);
            exp_hi.push_back(hi);
            exp_sum.push_back(s);
            act.push_back(s);
        end
        exp_root = act[0];
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_job(input bit hammer, input int hold, input int lat);
        int cyc;
        stale_hold   = hold;
        sort_latency = lat;
        model_job();
        got_lo.delete();
        got_hi.delete();
        got_sum.delete();
        got_idx.delete();
        got_sv.delete();
        n_sort_req = 0;
        @(negedge clock);
        for (int k = 0; k < DEPTH; k++) in_weights[k*8 +: 8] = 8'(job_w[k]);
        start = 1'b1;
        @(negedge clock);
        if (!hammer) start = 1'b0;
        check("busy_after_start", busy, 1);
        check("sort_valid_after_start", sort_valid, 1);
        cyc = 0;
        while (done !== 1'b1 && cyc < 4000) begin
            @(negedge clock);
            cyc++;
        end
        start = 1'b0;
        check("done_seen", done, 1);
        check("busy_low_with_done", busy, 0);
        check("root_weight", root_weight, exp_root);
        check("merge_count", got_lo.size(), DEPTH - 1);
        check("sort_req_count", n_sort_req, DEPTH - 1);
        for (int i = 0; i < DEPTH - 1 && i < got_lo.size(); i++) begin
            check($sformatf("merge%0d_lo", i), got_lo[i], exp_lo[i]);
            check($sformatf("merge%0d_hi", i), got_hi[i], exp_hi[i]);
            check($sformatf("merge%0d_sum", i), got_sum[i], exp_sum[i]);
            check($sformatf("merge%0d_idx", i), got_idx[i], i);
            check($sformatf("merge%0d_with_issue", i), got_sv[i], (i < DEPTH - 2) ? 1 : 0);
        end
        @(negedge clock);
        check("done_one_cycle", done, 0);
        check("idle_after_job", busy, 0);
        check("root_held", root_weight, exp_root);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;

        // Reset state
        rstn = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_sort_valid", sort_valid, 0);
        check("rst_sort_data", sort_data, 0);
        check("rst_merge_valid", merge_valid, 0);
        check("rst_merge_idx", merge_idx, 0);
        check("rst_done", done, 0);
        check("rst_root", root_weight, 0);
        rstn = 1'b1;

        // DEPTH=1: root after two cycles, no sorter request
        @(negedge clock);
        start1 = 1'b1;
        @(negedge clock);
        start1 = 1'b0;
        check("d1_busy", busy1, 1);
        check("d1_done_early", done1, 0);
        check("d1_no_sort_a", sort_valid1, 0);
        @(negedge clock);
        check("d1_done", done1, 1);
        check("d1_root", root_weight1, 9);
        check("d1_busy_low", busy1, 0);
        check("d1_no_sort_b", sort_valid1, 0);
        @(negedge clock);
        check("d1_done_pulse", done1, 0);
        check("d1_root_held", root_weight1, 9);

        // Directed jobs
        job_w = '{5, 1, 1, 2, 3, 8, 4, 2};
        run_job(1'b0, 0, 10);
        check("directed_root_26", root_weight, 26);

        job_w = '{200, 100, 0, 0, 0, 0, 0, 0};
        run_job(1'b0, 0, 3);

        job_w = '{1, 1, 1, 1, 0, 0, 0, 0};
        run_job(1'b0, 3, 4);

        job_w = '{255, 255, 255, 255, 255, 255, 255, 255};
        run_job(1'b0, 1, 1);

        // start held high for the whole job
        for (int k = 0; k < DEPTH; k++) job_w[k] = int'($urandom_range(0, 40));
        run_job(1'b1, 2, 5);

        // Random jobs
        for (int j = 0; j < 8; j++) begin
            for (int k = 0; k < DEPTH; k++)
                job_w[k] = (j % 2 == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 31));
            run_job(1'b0, int'($urandom_range(0, 3)), int'($urandom_range(1, 12)));
        end

        // Reset during WAIT_HI of round 2
        stale_hold   = 0;
        sort_latency = 10;
        n_sort_req   = 0;
        @(negedge clock);
        for (int k = 0; k < DEPTH; k++) in_weights[k*8 +: 8] = 8'($urandom_range(1, 255));
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cyc = 0;
        while (n_sort_req < 2 && cyc < 500) begin
            @(negedge clock);
            cyc++;
        end
        check("round2_issued", (n_sort_req >= 2) ? 1 : 0, 1);
        repeat (4) @(negedge clock);
        check("midjob_busy", busy, 1);
        rstn = 1'b0;
        @(negedge clock);
        check("mrst_busy", busy, 0);
        check("mrst_sort_valid", sort_valid, 0);
        check("mrst_sort_data", sort_data, 0);
        check("mrst_merge_valid", merge_valid, 0);
        check("mrst_merge_lo", merge_lo, 0);
        check("mrst_merge_hi", merge_hi, 0);
        check("mrst_merge_sum", merge_sum, 0);
        check("mrst_merge_idx", merge_idx, 0);
        check("mrst_done", done, 0);
        check("mrst_root", root_weight, 0);
        rstn = 1'b1;

        for (int k = 0; k < DEPTH; k++) job_w[k] = int'($urandom_range(0, 100));
        run_job(1'b0, 0, 6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
